// File: rtl/arch_verif_coverage_if.sv
`default_nettype none
// ============================================================================
// Module      : arch_verif_coverage_if
// Description : One retired-instruction trace record, sampled every clock.
//               The trace source drives it (master) and the coverage
//               collector samples it (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface arch_verif_coverage_if #(
    parameter int XLEN = 64
) ();
    logic            valid;
    logic [63:0]     order;
    logic [31:0]     insn;
    logic            trap;
    logic            debug_mode;
    logic [XLEN-1:0] pc_rdata;
    logic [1:0]      mode;
    logic            m_ext_intr;
    logic            s_ext_intr;
    logic            m_timer_intr;
    logic            m_soft_intr;
    logic [31:0]     x_wb;
    logic [31:0]     f_wb;

    modport master (
        output valid, order, insn, trap, debug_mode, pc_rdata, mode,
               m_ext_intr, s_ext_intr, m_timer_intr, m_soft_intr, x_wb, f_wb
    );

    modport slave (
        input  valid, order, insn, trap, debug_mode, pc_rdata, mode,
               m_ext_intr, s_ext_intr, m_timer_intr, m_soft_intr, x_wb, f_wb
    );
endinterface
`default_nettype wire

// File: rtl/arch_verif_coverage.sv
`default_nettype none
// ============================================================================
// Module      : arch_verif_coverage
// Description : Functional-coverage collector for a single-hart retirement
//               trace. Accumulates sticky opcode/compressed/mode/register/
//               interrupt bins, retire and trap counters, and a retirement
//               order check. Read back at end of test.
// Revision    : 1.0 - initial release
// ============================================================================
module arch_verif_coverage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  wire                      clk,
    input  wire                      reset,
    input  wire                      clear,
    arch_verif_coverage_if.slave     trace,
    output logic [31:0]              opcode_bins,
    output logic [2:0]               cq_bins,
    output logic [2:0]               mode_bins,
    output logic [31:0]              xreg_bins,
    output logic [31:0]              freg_bins,
    output logic [3:0]               intr_bins,
    output logic [CNT_W-1:0]         instret_cnt,
    output logic [CNT_W-1:0]         trap_cnt,
    output logic [XLEN-1:0]          last_pc,
    output logic                     order_err,
    output logic                     mode_err,
    output logic [7:0]               bins_covered
);

    localparam logic [1:0] MODE_U   = 2'd0;
    localparam logic [1:0] MODE_S   = 2'd1;
    localparam logic [1:0] MODE_RSV = 2'd2;
    localparam logic [1:0] MODE_M   = 2'd3;

    logic [31:0]      opcode_bins_q, opcode_bins_d;
    logic [2:0]       cq_bins_q,     cq_bins_d;
    logic [2:0]       mode_bins_q,   mode_bins_d;
    logic [31:0]      xreg_bins_q,   xreg_bins_d;
    logic [31:0]      freg_bins_q,   freg_bins_d;
    logic [3:0]       intr_bins_q,   intr_bins_d;
    logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;
    logic [CNT_W-1:0] trap_cnt_q,    trap_cnt_d;
    logic [XLEN-1:0]  last_pc_q,     last_pc_d;
    logic             order_err_q,   order_err_d;
    logic             mode_err_q,    mode_err_d;
    logic [63:0]      exp_order_q,   exp_order_d;
    logic             first_q,       first_d;

    logic             accept;
    logic [105:0]     all_bins;
    logic [7:0]       bin_count;

    // Upper instruction bits play no part in the bins.
    logic             unused_insn_hi;
    assign unused_insn_hi = ^trace.insn[31:7];

    // Debug-mode records are not architectural retirements and are ignored.
    assign accept = trace.valid & ~trace.debug_mode;

    // Next-state for every bin, counter and order-check register.
    always_comb begin
        opcode_bins_d = opcode_bins_q;
        cq_bins_d     = cq_bins_q;
        mode_bins_d   = mode_bins_q;
        xreg_bins_d   = xreg_bins_q;
        freg_bins_d   = freg_bins_q;
        intr_bins_d   = intr_bins_q;
        instret_cnt_d = instret_cnt_q;
        trap_cnt_d    = trap_cnt_q;
        last_pc_d     = last_pc_q;
        order_err_d   = order_err_q;
        mode_err_d    = mode_err_q;
        exp_order_d   = exp_order_q;
        first_d       = first_q;

        if (clear) begin
            // Clear wins over a same-cycle record, which is dropped.
            opcode_bins_d = '0;
            cq_bins_d     = '0;
            mode_bins_d   = '0;
            xreg_bins_d   = '0;
            freg_bins_d   = '0;
            intr_bins_d   = '0;
            instret_cnt_d = '0;
            trap_cnt_d    = '0;
            last_pc_d     = '0;
            order_err_d   = 1'b0;
            mode_err_d    = 1'b0;
            exp_order_d   = '0;
            first_d       = 1'b1;
        end else if (accept) begin
            last_pc_d = trace.pc_rdata;

            case (trace.mode)
                MODE_U:   mode_bins_d[0] = 1'b1;
                MODE_S:   mode_bins_d[1] = 1'b1;
                MODE_M:   mode_bins_d[2] = 1'b1;
                MODE_RSV: mode_err_d     = 1'b1;
                default:  mode_err_d     = 1'b1;
            endcase

            intr_bins_d = intr_bins_q | {trace.m_soft_intr, trace.m_timer_intr,
                                         trace.s_ext_intr,  trace.m_ext_intr};

            if (trace.trap) begin
                // A trapped instruction did not retire: only the trap count moves.
                if (!(&trap_cnt_q)) begin
                    trap_cnt_d = trap_cnt_q + CNT_W'(1);
                end
            end else begin
                if (!(&instret_cnt_q)) begin
                    instret_cnt_d = instret_cnt_q + CNT_W'(1);
                end
                if (trace.insn[1:0] == 2'b11) begin
                    opcode_bins_d[trace.insn[6:2]] = 1'b1;
                end else begin
                    cq_bins_d[trace.insn[1:0]] = 1'b1;
                end
                // x0 is hardwired to zero, so a write to it is never coverage.
                xreg_bins_d = xreg_bins_q | (trace.x_wb & 32'hFFFF_FFFE);
                freg_bins_d = freg_bins_q | trace.f_wb;
            end

            // Always resynchronise the expected sequence number, so a single
            // gap is flagged once rather than cascading.
            if (!first_q && (trace.order != exp_order_q)) begin
                order_err_d = 1'b1;
            end
            exp_order_d = trace.order + 64'd1;
            first_d     = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode_bins_q <= '0;
            cq_bins_q     <= '0;
            mode_bins_q   <= '0;
            xreg_bins_q   <= '0;
            freg_bins_q   <= '0;
            intr_bins_q   <= '0;
            instret_cnt_q <= '0;
            trap_cnt_q    <= '0;
            last_pc_q     <= '0;
            order_err_q   <= 1'b0;
            mode_err_q    <= 1'b0;
            exp_order_q   <= '0;
            first_q       <= 1'b1;
        end else begin
            opcode_bins_q <= opcode_bins_d;
            cq_bins_q     <= cq_bins_d;
            mode_bins_q   <= mode_bins_d;
            xreg_bins_q   <= xreg_bins_d;
            freg_bins_q   <= freg_bins_d;
            intr_bins_q   <= intr_bins_d;
            instret_cnt_q <= instret_cnt_d;
            trap_cnt_q    <= trap_cnt_d;
            last_pc_q     <= last_pc_d;
            order_err_q   <= order_err_d;
            mode_err_q    <= mode_err_d;
            exp_order_q   <= exp_order_d;
            first_q       <= first_d;
        end
    end

    assign all_bins = {opcode_bins_q, cq_bins_q, mode_bins_q,
                       xreg_bins_q, freg_bins_q, intr_bins_q};

    // Population count over every registered bin bit.
    always_comb begin
        bin_count = '0;
        for (int i = 0; i < 106; i++) begin
            bin_count = bin_count + {7'd0, all_bins[i]};
        end
    end

    assign opcode_bins  = opcode_bins_q;
    assign cq_bins      = cq_bins_q;
    assign mode_bins    = mode_bins_q;
    assign xreg_bins    = xreg_bins_q;
    assign freg_bins    = freg_bins_q;
    assign intr_bins    = intr_bins_q;
    assign instret_cnt  = instret_cnt_q;
    assign trap_cnt     = trap_cnt_q;
    assign last_pc      = last_pc_q;
    assign order_err    = order_err_q;
    assign mode_err     = mode_err_q;
    assign bins_covered = bin_count;

endmodule
`default_nettype wire

// File: tb/tb_arch_verif_coverage.sv
`default_nettype none
// ============================================================================
// Module      : tb_arch_verif_coverage
// Description : Scoreboard bench for arch_verif_coverage. A driver issues
//               directed and random trace records and pushes the reference
//               model's expected state; a monitor pops and compares after
//               every clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arch_verif_coverage;

    localparam int XLEN  = 64;
    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    logic clear;

    logic [31:0]      opcode_bins;
    logic [2:0]       cq_bins;
    logic [2:0]       mode_bins;
    logic [31:0]      xreg_bins;
    logic [31:0]      freg_bins;
    logic [3:0]       intr_bins;
    logic [CNT_W-1:0] instret_cnt;
    logic [CNT_W-1:0] trap_cnt;
    logic [XLEN-1:0]  last_pc;
    logic             order_err;
    logic             mode_err;
    logic [7:0]       bins_covered;

    arch_verif_coverage_if #(.XLEN(XLEN)) tr ();

    arch_verif_coverage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .trace        (tr),
        .opcode_bins  (opcode_bins),
        .cq_bins      (cq_bins),
        .mode_bins    (mode_bins),
        .xreg_bins    (xreg_bins),
        .freg_bins    (freg_bins),
        .intr_bins    (intr_bins),
        .instret_cnt  (instret_cnt),
        .trap_cnt     (trap_cnt),
        .last_pc      (last_pc),
        .order_err    (order_err),
        .mode_err     (mode_err),
        .bins_covered (bins_covered)
    );

    always #5 clk = ~clk;

    // Reference model state: plain bit arrays and integer counters.
    typedef struct {
        bit        opc [32];
        bit        cq  [3];
        bit        md  [3];
        bit        xr  [32];
        bit        fr  [32];
        bit        ir  [4];
        int        inst;
        int        trp;
        bit [63:0] lpc;
        bit        oerr;
        bit        merr;
        bit        first;
        bit [63:0] nxt;
    } model_t;

    typedef struct {
        bit [31:0] opc;
        bit [2:0]  cq;
        bit [2:0]  md;
        bit [31:0] xr;
        bit [31:0] fr;
        bit [3:0]  ir;
        int        inst;
        int        trp;
        bit [63:0] lpc;
        bit        oerr;
        bit        merr;
        int        cov;
    } snap_t;

    model_t m;
    snap_t  sb[$];
    int     checks = 0;
    int     errors = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        foreach (m.opc[i]) m.opc[i] = 0;
        foreach (m.cq[i])  m.cq[i]  = 0;
        foreach (m.md[i])  m.md[i]  = 0;
        foreach (m.xr[i])  m.xr[i]  = 0;
        foreach (m.fr[i])  m.fr[i]  = 0;
        foreach (m.ir[i])  m.ir[i]  = 0;
        m.inst = 0; m.trp = 0; m.lpc = 0;
        m.oerr = 0; m.merr = 0; m.first = 1; m.nxt = 0;
    endfunction

    function automatic snap_t snapshot();
        snap_t s;
        s.cov = 0;
        for (int i = 0; i < 32; i++) begin
            s.opc[i] = m.opc[i]; s.xr[i] = m.xr[i]; s.fr[i] = m.fr[i];
            s.cov += int'(m.opc[i]) + int'(m.xr[i]) + int'(m.fr[i]);
        end
        for (int i = 0; i < 3; i++) begin
            s.cq[i] = m.cq[i]; s.md[i] = m.md[i];
            s.cov += int'(m.cq[i]) + int'(m.md[i]);
        end
        for (int i = 0; i < 4; i++) begin
            s.ir[i] = m.ir[i];
            s.cov += int'(m.ir[i]);
        end
        s.inst = m.inst; s.trp = m.trp; s.lpc = m.lpc;
        s.oerr = m.oerr; s.merr = m.merr;
        return s;
    endfunction

    // Apply one record to the model using the architectural rules.
    function automatic void model_step(bit v, bit dbg, bit trp, bit clr,
                                       bit [63:0] ord, bit [31:0] ins,
                                       bit [1:0] md, bit [3:0] intr,
                                       bit [31:0] xw, bit [31:0] fw,
                                       bit [63:0] pc);
        int mi;
        if (clr) begin
            model_clear();
            return;
        end
        if (!v || dbg) return;
        m.lpc = pc;
        if (md == 2) m.merr = 1;
        else begin
            mi = (md == 3) ? 2 : int'(md);
            m.md[mi] = 1;
        end
        for (int i = 0; i < 4; i++) if (intr[i]) m.ir[i] = 1;
        if (trp) begin
            if (m.trp < CMAX) m.trp++;
        end else begin
            if (m.inst < CMAX) m.inst++;
            if (ins[1:0] == 2'b11) m.opc[int'(ins[6:2])] = 1;
            else                   m.cq[int'(ins[1:0])]  = 1;
            for (int i = 1; i < 32; i++) if (xw[i]) m.xr[i] = 1;
            for (int i = 0; i < 32; i++) if (fw[i]) m.fr[i] = 1;
        end
        if (!m.first && ord != m.nxt) m.oerr = 1;
        m.nxt   = ord + 64'd1;
        m.first = 0;
    endfunction

    // Issue one record at the falling edge and queue the expected result.
    // intr = {m_soft, m_timer, s_ext, m_ext}.
    task automatic send(input bit v, input bit dbg, input bit trp, input bit clr,
                        input bit [63:0] ord, input bit [31:0] ins,
                        input bit [1:0] md, input bit [3:0] intr,
                        input bit [31:0] xw, input bit [31:0] fw,
                        input bit [63:0] pc);
        @(negedge clk);
        tr.valid        = v;
        tr.debug_mode   = dbg;
        tr.trap         = trp;
        clear           = clr;
        tr.order        = ord;
        tr.insn         = ins;
        tr.mode         = md;
        tr.m_ext_intr   = intr[0];
        tr.s_ext_intr   = intr[1];
        tr.m_timer_intr = intr[2];
        tr.m_soft_intr  = intr[3];
        tr.x_wb         = xw;
        tr.f_wb         = fw;
        tr.pc_rdata     = pc;
        model_step(v, dbg, trp, clr, ord, ins, md, intr, xw, fw, pc);
        sb.push_back(snapshot());
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_opc"},  64'(opcode_bins), 0);
        chk({tag, "_cq"},   64'(cq_bins), 0);
        chk({tag, "_mode"}, 64'(mode_bins), 0);
        chk({tag, "_xreg"}, 64'(xreg_bins), 0);
        chk({tag, "_freg"}, 64'(freg_bins), 0);
        chk({tag, "_intr"}, 64'(intr_bins), 0);
        chk({tag, "_inst"}, 64'(instret_cnt), 0);
        chk({tag, "_trap"}, 64'(trap_cnt), 0);
        chk({tag, "_pc"},   64'(last_pc), 0);
        chk({tag, "_oerr"}, 64'(order_err), 0);
        chk({tag, "_merr"}, 64'(mode_err), 0);
        chk({tag, "_cov"},  64'(bins_covered), 0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must drop without an edge.
    task automatic pulse_reset();
        @(negedge clk);
        tr.valid = 1'b0;
        reset    = 1'b1;
        #1;
        check_all_zero("rst");
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: compare DUT state with the queued expectation after each edge.
    always @(posedge clk) begin
        snap_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("opcode_bins",  64'(opcode_bins),  64'(e.opc));
            chk("cq_bins",      64'(cq_bins),      64'(e.cq));
            chk("mode_bins",    64'(mode_bins),    64'(e.md));
            chk("xreg_bins",    64'(xreg_bins),    64'(e.xr));
            chk("freg_bins",    64'(freg_bins),    64'(e.fr));
            chk("intr_bins",    64'(intr_bins),    64'(e.ir));
            chk("instret_cnt",  64'(instret_cnt),  64'(e.inst));
            chk("trap_cnt",     64'(trap_cnt),     64'(e.trp));
            chk("last_pc",      64'(last_pc),      e.lpc);
            chk("order_err",    64'(order_err),    64'(e.oerr));
            chk("mode_err",     64'(mode_err),     64'(e.merr));
            chk("bins_covered", 64'(bins_covered), 64'(e.cov));
        end
    end

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        bit [63:0] ord;
        bit [31:0] ins;
        model_clear();
        reset = 1'b1; clear = 1'b0;
        tr.valid = 0; tr.debug_mode = 0; tr.trap = 0; tr.order = 0;
        tr.insn = 0; tr.mode = 0; tr.m_ext_intr = 0; tr.s_ext_intr = 0;
        tr.m_timer_intr = 0; tr.m_soft_intr = 0; tr.x_wb = 0; tr.f_wb = 0;
        tr.pc_rdata = 0;
        #3;
        check_all_zero("init");
        @(negedge clk);
        reset = 1'b0;

        // addi x0,x0,0 in M-mode
        send(1, 0, 0, 0, 64'd1, 32'h0000_0013, 2'd3, 4'h0, 32'h1, 32'h0, 64'h8000_0000);
        settle();
        chk("addi_opc",  64'(opcode_bins), 64'h10);
        chk("addi_xreg", 64'(xreg_bins), 0);
        chk("addi_mode", 64'(mode_bins), 64'h4);
        chk("addi_inst", 64'(instret_cnt), 1);
        chk("addi_cov",  64'(bins_covered), 2);

        // c.li
        send(1, 0, 0, 0, 64'd2, 32'h0000_4501, 2'd3, 4'h0, 32'h0, 32'h4, 64'h8000_0004);
        settle();
        chk("cli_cq",   64'(cq_bins), 64'h2);
        chk("cli_freg", 64'(freg_bins), 64'h4);

        // trapping ecall
        send(1, 0, 1, 0, 64'd3, 32'h0000_0073, 2'd3, 4'h0, 32'h20, 32'h0, 64'h8000_0006);
        settle();
        chk("trap_cnt",  64'(trap_cnt), 1);
        chk("trap_inst", 64'(instret_cnt), 2);
        chk("trap_opc",  64'(opcode_bins), 64'h10);
        chk("trap_xreg", 64'(xreg_bins), 0);

        // clear with a valid record: record dropped
        send(1, 0, 0, 1, 64'd77, 32'h0000_0033, 2'd1, 4'hF, 32'hFF, 32'hFF, 64'h1234);
        settle();
        check_all_zero("clr");
        clear = 1'b0;

        // order sequence 5,6,8,9 then a debug record
        send(1, 0, 0, 0, 64'd5, 32'h0000_0013, 2'd0, 4'h0, 32'h0, 32'h0, 64'h100);
        send(1, 0, 1, 0, 64'd6, 32'h0000_0013, 2'd0, 4'h0, 32'h0, 32'h0, 64'h104);
        settle();
        chk("ord_ok", 64'(order_err), 0);
        send(1, 0, 0, 0, 64'd8, 32'h0000_0013, 2'd0, 4'h0, 32'h0, 32'h0, 64'h108);
        settle();
        chk("ord_gap", 64'(order_err), 1);
        send(1, 0, 0, 0, 64'd9, 32'h0000_0013, 2'd0, 4'h0, 32'h0, 32'h0, 64'h10C);
        send(1, 1, 0, 0, 64'd55, 32'h0000_0063, 2'd2, 4'hF, 32'hFF, 32'hFF, 64'hDEAD);
        settle();
        chk("ord_sticky", 64'(order_err), 1);
        chk("dbg_pc",     64'(last_pc), 64'h10C);
        chk("dbg_merr",   64'(mode_err), 0);

        // reserved mode
        send(1, 0, 0, 0, 64'd10, 32'h0000_0013, 2'd2, 4'h0, 32'h0, 32'h0, 64'h110);
        settle();
        chk("rsv_merr", 64'(mode_err), 1);
        chk("rsv_mode", 64'(mode_bins), 64'h1);

        // counter saturation
        send(0, 0, 0, 1, 64'd0, 32'h0, 2'd0, 4'h0, 32'h0, 32'h0, 64'h0);
        for (int i = 0; i < CMAX + 6; i++) begin
            send(1, 0, 0, 0, 64'(i), 32'h0000_0013, 2'd3, 4'h0, 32'h0, 32'h0, 64'(4 * i));
        end
        settle();
        chk("sat_inst", 64'(instret_cnt), 64'(CMAX));

        // random traffic with a mid-run reset
        ord = 64'd100;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) pulse_reset();
            ins = $urandom();
            if ($urandom_range(0, 9) < 8) ord = ord + 64'd1;
            else ord = ord + 64'($urandom_range(0, 3));
            send($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 49) == 0,
                 ord, ins, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0) ? 4'($urandom()) : 4'h0,
                 32'(1) << $urandom_range(0, 31),
                 ($urandom_range(0, 3) == 0) ? (32'(1) << $urandom_range(0, 31)) : 32'h0,
                 {$urandom(), $urandom()});
        end
        @(negedge clk);
        clear = 1'b0;
        tr.valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", 64'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arch_verif_coverage.md
Name: arch_verif_coverage

Overview:
Hardware functional-coverage collector for a single-hart RVVI-style retirement trace. Each clock it samples one retired-instruction record: valid, instruction, trap, mode, interrupts and register write-back masks. From these it accumulates sticky coverage bins, event counters and a trace-ordering check. It sits beside the architectural-verification harness and is read back at end of test.

Parameters:
XLEN, 64, width of pc_rdata (32 or 64)
CNT_W, 32, width of the instret_cnt and trap_cnt counters

Ports:
clk  in  1  sampling clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous clear of all bins, counters and flags
valid  in  1  trace record present this cycle
order  in  64  retirement sequence number of the record
insn  in  32  instruction word (compressed in low 16 bits when insn[1:0]!=2'b11)
trap  in  1  instruction trapped and did not retire
debug_mode  in  1  record retired in debug mode
pc_rdata  in  XLEN  PC of record; captured only
mode  in  2  privilege: 0=U, 1=S, 3=M, 2=reserved
m_ext_intr, s_ext_intr, m_timer_intr, m_soft_intr  in  1 each  interrupt indications
x_wb  in  32  integer register write mask
f_wb  in  32  FP register write mask
opcode_bins  out  32  bit k set once a 32-bit insn with insn[6:2]==k retired
cq_bins  out  3  bit q set once a compressed insn with insn[1:0]==q retired
mode_bins  out  3  [0]=U, [1]=S, [2]=M seen
xreg_bins  out  32  x registers written; bit 0 is always 0
freg_bins  out  32  f registers written
intr_bins  out  4  {m_soft, m_timer, s_ext, m_ext} seen
instret_cnt  out  CNT_W  retired, non-trapping records
trap_cnt  out  CNT_W  trapping records
last_pc  out  XLEN  pc_rdata of the last accepted record
order_err  out  1  sticky sequence violation
mode_err  out  1  sticky reserved-mode record
bins_covered  out  8  popcount of all bin bits (max 105)

Behaviour:
- Reset (async) or clear (sync): all outputs and internal state go to 0, and the "first record" flag is set. Clear beats a same-cycle valid; that record is dropped.
- Accepted record: valid=1, debug_mode=0, and neither reset nor clear active. Records with valid=0 or debug_mode=1 change nothing.
- All updates are registered and appear the cycle after the sampling edge. bins_covered is combinational from the registered bins.
- On every accepted record:
  - last_pc <= pc_rdata.
  - Mode bin set. mode==2 sets mode_err and sets no mode bin.
  - Each asserted interrupt input sets its intr_bins bit.
- Accepted record with trap=1: trap_cnt increments. No opcode, cq, xreg or freg bin changes.
- Accepted record with trap=0:
  - instret_cnt increments.
  - If insn[1:0]==2'b11, set opcode_bins[insn[6:2]]; otherwise set cq_bins[insn[1:0]].
  - xreg_bins |= x_wb & ~1.
  - freg_bins |= f_wb.
- Counters saturate at all-ones; they never wrap.
- Order check:
  - First accepted record after reset/clear loads expected = order+1 and cannot set order_err.
  - Each later accepted record with order != expected sets order_err (sticky).
  - expected <= order+1 on every accepted record, so checking resynchronises after a violation.
  - Trapping records participate in the order check.
- Bins are sticky: once set, cleared only by reset or clear.

Test Plan:
- Reset mid-run after bins and counters are nonzero -> every output is 0 immediately, with no clock edge required.
- Accepted insn=0x00000013 (addi), x_wb=0x00000001, mode=3, order=1 -> next cycle opcode_bins=0x00000010, xreg_bins=0, mode_bins=3'b100, instret_cnt=1, bins_covered=2.
- Accepted insn=0x00004501 (c.li), trap=0, f_wb=0x00000004 -> cq_bins=3'b010, freg_bins=0x00000004.
- Accepted trap=1, insn=0x00000073, x_wb=0x20 -> trap_cnt=1, instret_cnt unchanged, opcode_bins and xreg_bins unchanged.
- Orders 5, 6, 8, 9 on successive accepted records -> order_err rises after the record with order 8 and stays 1; a valid=1, debug_mode=1 record with any order changes nothing.
- mode=2 record -> mode_err=1, mode_bins unchanged. clear together with a valid record -> all state 0 and the record is ignored. instret_cnt preloaded to 0xFFFFFFFF stays at 0xFFFFFFFF after one more retirement.
